// File: rtl/wb_port_arb.sv
// Shares the register-file write port between pipeline writeback (priority) and the MDU result port.
// The starvation counter forces a pipeline stall. A one-entry hold register absorbs the pipeline write that collides during STALL.
module wb_port_arb #(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 5,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_wd,
    input  logic [AW-1:0] pipe_wreg,
    input  logic [DW-1:0] pipe_wdata,
    input  logic          mdu_valid,
    input  logic [AW-1:0] mdu_wreg,
    input  logic [DW-1:0] mdu_wdata,
    output logic          mdu_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          stall_req,
    output logic          err_ovf
);

    localparam int CW = $clog2(STARVE_MAX) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_MAX - 1);
    localparam logic [CW-1:0] CNT_SAT  = '1;

    typedef enum logic [1:0] {IDLE, STALL, DRAIN} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    wr_t           hold_q;
    logic          rf_we_q;
    logic [AW-1:0] rf_waddr_q;
    logic [DW-1:0] rf_wdata_q;
    logic          stall_req_q;
    logic          err_ovf_q;
    logic          pipe_req;

    // Writes to register 0 are architecturally void, so they never compete for the port.
    assign pipe_req = pipe_wd & (pipe_wreg != '0);
    assign cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        mdu_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:    mdu_ready = !pipe_req;
                STALL:   mdu_ready = 1'b1;
                default: mdu_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            stall_req_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            rf_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pipe_req) begin
                        rf_we_q    <= 1'b1;
                        rf_waddr_q <= pipe_wreg;
                        rf_wdata_q <= pipe_wdata;
                    end else if (mdu_valid) begin
                        rf_we_q    <= (mdu_wreg != '0);
                        rf_waddr_q <= mdu_wreg;
                        rf_wdata_q <= mdu_wdata;
                    end
                    if (mdu_valid && pipe_req) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q     <= STALL;
                            stall_req_q <= 1'b1;
                            cnt_q       <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                STALL: begin
                    if (mdu_valid) begin
                        rf_we_q    <= (mdu_wreg != '0);
                        rf_waddr_q <= mdu_wreg;
                        rf_wdata_q <= mdu_wdata;
                    end
                    // The one pipeline write still in flight when the stall lands is parked here.
                    if (pipe_req) begin
                        hold_q  <= '{addr: pipe_wreg, data: pipe_wdata};
                        state_q <= DRAIN;
                    end else begin
                        state_q     <= IDLE;
                        stall_req_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    rf_we_q     <= 1'b1;
                    rf_waddr_q  <= hold_q.addr;
                    rf_wdata_q  <= hold_q.data;
                    stall_req_q <= 1'b0;
                    state_q     <= IDLE;
                    if (pipe_req) begin
                        err_ovf_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign stall_req = stall_req_q;
    assign err_ovf   = err_ovf_q;

endmodule
